cbus_line_initiator: RTL and testbench
======================================

# cbus_line_initiator

Initiator-side CBus engine that turns one cache-line refill or writeback request into a single INCR burst of 64-bit beats, and reports completion back to the cache. Sits between the data cache miss logic and the CBus arbiter/SRAM responder. Drives exactly one outstanding transaction at a time and holds all request fields stable for the whole burst.

## Interface
- LINE_WORDS, 8: beats per line, power of two, 2..16; CBus len = LINE_WORDS-1.
- TIMEOUT_CYCLES, 4096: watchdog limit, used only with the watchdog macro.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- line_valid  in  1  cache requests a line transfer.
- line_write  in  1  1 = writeback, 0 = refill.
- line_addr  in  64  line base address; low log2(LINE_WORDS)+3 bits ignored and forced to 0.
- line_wdata  in  64*LINE_WORDS  writeback data, word 0 in bits [63:0].
- line_ready  out  1  high in IDLE; request accepted when line_valid && line_ready.
- line_done  out  1  one-cycle completion pulse.
- line_rdata  out  64*LINE_WORDS  refill data, valid from line_done onward until the next accept.
- line_err  out  1  sticky protocol/timeout error, cleared only by reset.
- creq  out  cbus_req_t  CBus request.
- cresp  in  cbus_resp_t  CBus response.

## Operation
- States: IDLE, BURST, DONE.
- IDLE: line_ready=1, creq.valid=0. On accept: latch is_write, aligned addr, wdata. Clear beat counter. Go to BURST.
- BURST: creq.valid=1, burst=AXI_BURST_INCR, size=MSIZE8, len=LINE_WORDS-1.
  - Writes: strobe=8'hFF, data = latched word[beat].
  - Reads: strobe=0, data=0.
- Beat handshake: every cycle with cresp.ready=1 is one beat.
  - Reads store cresp.data into word[beat].
  - The beat counter increments (log2(LINE_WORDS) bits, no wrap past LINE_WORDS-1).
- cresp.ready && cresp.last ends the burst: go to DONE.
  - If beat != LINE_WORDS-1 at that point, set line_err; still finish.
- cresp.ready && !cresp.last at beat == LINE_WORDS-1 sets line_err. Stay in BURST, counter holds, data word LINE_WORDS-1 is overwritten, until last arrives.
- cresp is ignored outside BURST.
- DONE: line_done=1, creq.valid=0, line_ready=0. Go to IDLE next cycle.
- creq fields other than valid hold their latched values in IDLE and DONE; they are not required to be zero.

## Timing
- Reset values:
  - state=IDLE, line_ready=1, line_done=0, line_err=0.
  - creq all-zero (valid=0).
  - line_rdata=0, beat counter=0.
- Accept at edge N: creq.valid=1 during cycle N+1.
- Zero-wait responder: beats in cycles N+1..N+LINE_WORDS, line_done in cycle N+LINE_WORDS+1, line_ready again in N+LINE_WORDS+2.
- Responder stalls (ready=0) only stretch BURST; creq is unchanged throughout.
- line_valid during BURST/DONE is ignored and not queued.
- Reset mid-burst: outputs take reset values on the reset edge. creq.valid drops in the next cycle, with no completion pulse. The responder must also be reset.
- All outputs are registered except line_ready, which is decoded from state.

## Configuration
- CBUS_WATCHDOG_EN defined:
  - A 32-bit counter runs in BURST and resets on every cresp.ready.
  - On reaching TIMEOUT_CYCLES: set line_err and force DONE (line_done pulses; partial line_rdata).
- CBUS_WATCHDOG_EN undefined: no counter; BURST waits indefinitely.

## Structure
- Shared package common: cbus_req_t, cbus_resp_t, AXI_BURST_*, MSIZE8, u64 (existing).
- New in common: the enum type line_state_t {IDLE, BURST, DONE} and the constant CBUS_WORD_BYTES=8.
- One natural sub-module: cbus_watchdog (counter + compare), instantiated only under CBUS_WATCHDOG_EN.
- Expected size: about 200 lines.

## Test plan
- Refill, zero-wait responder, addr 0x8000_0047:
  - creq.addr = 0x8000_0040, len = 7.
  - 8 beats of data 0x11..0x88.
  - line_done 9 cycles after accept.
  - line_rdata word0 = 0x11, word7 = 0x88; line_err = 0.
- Writeback with ready on alternate cycles, wdata words 0xA0..0xA7:
  - creq.data steps 0xA0..0xA7 only after each ready; strobe = 0xFF.
  - line_done 17 cycles after accept.
- Responder asserts last on beat 5: line_err=1 and line_done pulses. A second line_valid is then accepted normally.
- line_valid held high continuously: exactly one transfer per IDLE visit; line_ready low during BURST and DONE.
- Reset asserted on beat 3 of a refill:
  - Next cycle: creq.valid=0, line_ready=1, line_rdata=0, no line_done.
  - A new refill completes correctly afterwards.
- With CBUS_WATCHDOG_EN and TIMEOUT_CYCLES=16, cresp.ready stuck at 0: line_err and line_done 17 cycles after accept. Without the macro, the block is still in BURST after 1000 cycles.

Source files
------------

// File: rtl/cbus_line_initiator_pkg.sv
// Shared CBus definitions for the line initiator: request/response
// structures, burst/size encodings, line FSM state type and an address
// alignment helper.
package cbus_line_initiator_pkg;

  typedef logic [63:0] u64;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] MSIZE8 = 3'd3;

  localparam int CBUS_WORD_BYTES = 8;

  typedef struct packed {
    logic       valid;
    u64         addr;
    logic [1:0] burst;
    logic [2:0] size;
    logic [7:0] len;
    logic       write;
    u64         data;
    logic [7:0] strobe;
  } cbus_req_t;

  typedef struct packed {
    logic ready;
    logic last;
    u64   data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } line_state_t;

  // Clear the byte-offset bits below a line boundary (line_bytes is a power of two).
  function automatic u64 line_align(input u64 addr, input int line_bytes);
    return addr & ~(u64'(line_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/cbus_line_initiator_watchdog.sv
// Burst watchdog: counts cycles in BURST without a responder handshake and
// flags expiry when the count is about to reach TIMEOUT_CYCLES.
module cbus_line_initiator_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: restart outside BURST and on every handshake, else advance.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || kick) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Expiry is seen in the cycle whose edge would take the count to the limit.
  assign expired = run && !kick && ((cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES));

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cbus_line_initiator.sv
// CBus line initiator: turns one cache-line refill or writeback into a single
// INCR burst of 64-bit beats and pulses line_done on completion.
// Optional feature macro: CBUS_WATCHDOG_EN (burst timeout watchdog).
module cbus_line_initiator
  import cbus_line_initiator_pkg::*;
#(
  parameter int LINE_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_valid,
  input  logic                    line_write,
  input  logic [63:0]             line_addr,
  input  logic [64*LINE_WORDS-1:0] line_wdata,
  output logic                    line_ready,
  output logic                    line_done,
  output logic [64*LINE_WORDS-1:0] line_rdata,
  output logic                    line_err,
  output cbus_req_t               creq,
  input  cbus_resp_t              cresp
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LINE_BYTES = LINE_WORDS * CBUS_WORD_BYTES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_BURST = BURST;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]                    state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [LINE_WORDS-1:0][63:0]   wdata_q, wdata_d;
  logic [LINE_WORDS-1:0][63:0]   rdata_q, rdata_d;
  logic                          err_q, err_d;
  logic                          done_q, done_d;
  cbus_req_t                     creq_q, creq_d;

  logic [LINE_WORDS-1:0][63:0]   line_wdata_s;
  logic [BEAT_W-1:0]             beat_nxt_s;
  logic                          wd_expired_s;

  assign line_wdata_s = line_wdata;

`ifdef CBUS_WATCHDOG_EN
  cbus_line_initiator_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == ST_BURST),
    .kick    (cresp.ready),
    .expired (wd_expired_s)
  );
`else
  // Without the watchdog a stalled burst simply waits for the responder.
  assign wd_expired_s = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // The counter parks on the final beat; extra beats reuse the last slot.
  assign beat_nxt_s = (beat_q == LAST_BEAT) ? beat_q : (beat_q + BEAT_W'(1));

  // Next-state, beat tracking, data capture and request generation.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = 1'b0;
    creq_d  = creq_q;

    case (state_q)
      ST_IDLE: begin
        if (line_valid) begin
          state_d       = ST_BURST;
          beat_d        = '0;
          wdata_d       = line_wdata_s;
          creq_d.valid  = 1'b1;
          creq_d.addr   = line_align(line_addr, LINE_BYTES);
          creq_d.burst  = AXI_BURST_INCR;
          creq_d.size   = MSIZE8;
          creq_d.len    = 8'(LINE_WORDS - 1);
          creq_d.write  = line_write;
          creq_d.strobe = line_write ? 8'hFF : 8'h00;
          creq_d.data   = line_write ? line_wdata_s[0] : 64'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BURST: begin
        if (cresp.ready) begin
          if (!creq_q.write) begin
            rdata_d[beat_q] = cresp.data;
          end else begin
            rdata_d = rdata_q;
          end
          if (cresp.last) begin
            // Burst ends on last regardless of how many beats arrived.
            if (beat_q != LAST_BEAT) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            state_d      = ST_DONE;
            done_d       = 1'b1;
            creq_d.valid = 1'b0;
          end else begin
            if (beat_q == LAST_BEAT) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            beat_d = beat_nxt_s;
            if (creq_q.write) begin
              creq_d.data = wdata_q[beat_nxt_s];
            end else begin
              creq_d.data = 64'd0;
            end
          end
        end else if (wd_expired_s) begin
          err_d        = 1'b1;
          state_d      = ST_DONE;
          done_d       = 1'b1;
          creq_d.valid = 1'b0;
        end else begin
          state_d = ST_BURST;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        creq_d.valid = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      creq_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      creq_q  <= creq_d;
    end
  end

  assign line_ready = (state_q == ST_IDLE);
  assign line_done  = done_q;
  assign line_err   = err_q;
  assign line_rdata = rdata_q;
  assign creq       = creq_q;

endmodule

// File: tb/tb_cbus_line_initiator.sv
// Self-checking bench for cbus_line_initiator: a scripted CBus responder and a
// line-level reference model (expected request, refill words, sticky error).
module tb_cbus_line_initiator;
  import cbus_line_initiator_pkg::*;

  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             line_valid;
  logic             line_write;
  logic [63:0]      line_addr;
  logic [64*LW-1:0] line_wdata;
  logic             line_ready;
  logic             line_done;
  logic [64*LW-1:0] line_rdata;
  logic             line_err;
  cbus_req_t        creq;
  cbus_resp_t       cresp;

  int n_checks = 0;
  int n_pass   = 0;

  u64   tx_wdata [LW];
  u64   tx_rdata [16];
  u64   model_w  [LW];
  logic err_model;

  cbus_line_initiator #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_valid (line_valid),
    .line_write (line_write),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_ready (line_ready),
    .line_done  (line_done),
    .line_rdata (line_rdata),
    .line_err   (line_err),
    .creq       (creq),
    .cresp      (cresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fill_random();
    for (int i = 0; i < LW; i++) tx_wdata[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) tx_rdata[i] = {$urandom, $urandom};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One line transfer. Called at #1 after an edge while the DUT is idle.
  // mode 0: always ready, 1: ready on even burst cycles, 2: random ready.
  // stall: forced not-ready cycles first. rst_at: beat count at which reset hits.
  task automatic run_txn(input logic wr, input u64 addr, input int nbeats, input int mode,
                         input int stall, input logic hold, input int rst_at);
    cbus_req_t        exp_req;
    logic [511:0]     exp_rd, mask;
    int               beats, cyc, bi;
    logic             rdy, lst, fin;
    check("idle_ready", 512'(line_ready), 512'(1'b1));
    line_valid = 1'b1;
    line_write = wr;
    line_addr  = addr;
    for (int i = 0; i < LW; i++) line_wdata[i*64 +: 64] = tx_wdata[i];
    next_cycle();
    if (!hold) line_valid = 1'b0;
    line_write = $urandom_range(0, 1) == 1;
    line_addr  = {$urandom, $urandom};
    line_wdata = {16{$urandom}};

    exp_req        = '0;
    exp_req.valid  = 1'b1;
    exp_req.addr   = addr & ~64'h3F;
    exp_req.burst  = 2'b01;
    exp_req.size   = 3'd3;
    exp_req.len    = 8'd7;
    exp_req.write  = wr;
    exp_req.strobe = wr ? 8'hFF : 8'h00;

    beats = 0;
    cyc   = 0;
    fin   = 1'b0;
    while (!fin && cyc < 3000) begin
      cyc++;
      if (rst_at >= 0 && beats == rst_at) begin
        reset = 1'b1;
        cresp = '0;
        next_cycle();
        check("rst_creq", 512'(creq), 512'(0));
        check("rst_ready", 512'(line_ready), 512'(1'b1));
        check("rst_rdata", 512'(line_rdata), 512'(0));
        check("rst_done", 512'(line_done), 512'(0));
        check("rst_err", 512'(line_err), 512'(0));
        reset     = 1'b0;
        err_model = 1'b0;
        for (int i = 0; i < LW; i++) model_w[i] = 64'd0;
        next_cycle();
        check("rst_no_done", 512'(line_done), 512'(0));
        check("rst_no_valid", 512'(creq.valid), 512'(0));
        return;
      end
      bi = (beats > LW - 1) ? LW - 1 : beats;
      exp_req.data = wr ? tx_wdata[bi] : 64'd0;
      check("creq", 512'(creq), 512'(exp_req));
      check("busy", 512'({line_ready, line_done}), 512'(0));
      if (cyc <= stall)   rdy = 1'b0;
      else if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = ($urandom_range(0, 2) != 0);
      lst = rdy && (beats == nbeats - 1);
      cresp.ready = rdy;
      cresp.last  = lst;
      cresp.data  = rdy ? tx_rdata[beats] : {$urandom, $urandom};
      if (rdy) begin
        if (!wr) model_w[bi] = tx_rdata[beats];
        beats++;
      end
      if (lst) fin = 1'b1;
      next_cycle();
    end
    cresp = '0;
    check("txn_bound", 512'(fin), 512'(1'b1));
    if (nbeats != LW) err_model = 1'b1;
    check("done_pulse", 512'(line_done), 512'(1'b1));
    check("done_ready", 512'(line_ready), 512'(0));
    check("done_valid", 512'(creq.valid), 512'(0));
    check("err", 512'(line_err), 512'(err_model));
    if (!wr) begin
      exp_rd = '0;
      mask   = '0;
      for (int i = 0; i < LW; i++) begin
        exp_rd[i*64 +: 64] = model_w[i];
        if (i < nbeats) mask[i*64 +: 64] = {64{1'b1}};
      end
      check("rdata", line_rdata & mask, exp_rd & mask);
    end
    next_cycle();
    check("post_done", 512'(line_done), 512'(0));
    check("post_ready", 512'(line_ready), 512'(1'b1));
    check("post_hold_addr", 512'(creq.addr), 512'(exp_req.addr));
  endtask

  initial begin
    reset      = 1'b1;
    line_valid = 1'b0;
    line_write = 1'b0;
    line_addr  = 64'd0;
    line_wdata = '0;
    cresp      = '0;
    err_model  = 1'b0;
    for (int i = 0; i < LW; i++) model_w[i] = 64'd0;
    repeat (3) next_cycle();
    check("reset_ready", 512'(line_ready), 512'(1'b1));
    check("reset_done", 512'(line_done), 512'(0));
    check("reset_err", 512'(line_err), 512'(0));
    check("reset_creq", 512'(creq), 512'(0));
    check("reset_rdata", 512'(line_rdata), 512'(0));
    reset = 1'b0;
    next_cycle();

    // Zero-wait refill of an unaligned address, data 0x11..0x88.
    fill_random();
    for (int i = 0; i < LW; i++) tx_rdata[i] = 64'(8'h11 * (i + 1));
    run_txn(1'b0, 64'h0000_0000_8000_0047, LW, 0, 0, 1'b0, -1);
    check("t1_addr", 512'(creq.addr), 512'(64'h8000_0040));
    check("t1_len", 512'(creq.len), 512'(8'd7));
    check("t1_word0", 512'(line_rdata[63:0]), 512'(64'h11));
    check("t1_word7", 512'(line_rdata[511:448]), 512'(64'h88));

    // Writeback with ready on alternate cycles, words 0xA0..0xA7.
    fill_random();
    for (int i = 0; i < LW; i++) tx_wdata[i] = 64'(8'hA0 + i);
    run_txn(1'b1, 64'h0000_1234_5678_9AC0, LW, 1, 0, 1'b0, -1);

    // Early last on beat index 5, then a normal refill.
    fill_random();
    run_txn(1'b0, {$urandom, $urandom}, 6, 2, 0, 1'b0, -1);
    fill_random();
    run_txn(1'b0, {$urandom, $urandom}, LW, 0, 0, 1'b0, -1);

    // Overrun: two extra beats overwrite the final word.
    fill_random();
    run_txn(1'b0, {$urandom, $urandom}, LW + 2, 2, 0, 1'b0, -1);
    fill_random();
    run_txn(1'b1, {$urandom, $urandom}, LW + 2, 0, 0, 1'b0, -1);

    // Reset during beat 3 of a refill, then a clean refill.
    fill_random();
    run_txn(1'b0, {$urandom, $urandom}, LW, 0, 0, 1'b0, 3);
    fill_random();
    run_txn(1'b0, {$urandom, $urandom}, LW, 0, 0, 1'b0, -1);

    // line_valid held high across back-to-back transfers.
    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_txn(t[0], {$urandom, $urandom}, LW, 0, 0, 1'b1, -1);
    end
    line_valid = 1'b0;
    next_cycle();
    check("hold_release_idle", 512'({line_ready, creq.valid}), 512'(2'b10));

    // Randomized transfers with random stalls and occasional bad beat counts.
    for (int t = 0; t < 12; t++) begin
      int nb;
      fill_random();
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(LW - 2, LW + 2) : LW;
      run_txn($urandom_range(0, 1) == 1, {$urandom, $urandom}, nb, 2, 0, 1'b0, -1);
    end

`ifdef CBUS_WATCHDOG_EN
    // Responder never ready: watchdog ends the burst 17 cycles after accept.
    line_valid = 1'b1;
    line_write = 1'b0;
    line_addr  = 64'h40;
    next_cycle();
    line_valid = 1'b0;
    cresp      = '0;
    for (int c = 1; c <= 16; c++) begin
      check("wd_wait", 512'(line_done), 512'(0));
      next_cycle();
    end
    check("wd_done", 512'(line_done), 512'(1'b1));
    check("wd_err", 512'(line_err), 512'(1'b1));
    next_cycle();
    check("wd_idle", 512'(line_ready), 512'(1'b1));
`else
    // Responder silent for 1000 cycles: burst stays open, then completes.
    fill_random();
    run_txn(1'b0, {$urandom, $urandom}, LW, 0, 1000, 1'b0, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
